// File: rtl/apu_dispatcher.sv
// apu_dispatcher: issues one FP operation at a time to an APU and returns results in grant order
// with a writeback strobe, sticky exception flags and a protocol-error flag.
module apu_dispatcher #(
    parameter int MAX_OUTST = 2,
    parameter int TAG_W     = 5
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              op_valid_i,
    output logic              op_ready_o,
    input  logic [2:0][31:0]  op_operands_i,
    input  logic [5:0]        op_code_i,
    input  logic [2:0]        op_rnd_i,
    input  logic [TAG_W-1:0]  op_tag_i,
    output logic              apu_req_o,
    input  logic              apu_gnt_i,
    output logic [2:0][31:0]  apu_operands_o,
    output logic [5:0]        apu_op_o,
    output logic [10:0]       apu_flags_o,
    input  logic              apu_rvalid_i,
    input  logic [31:0]       apu_rdata_i,
    input  logic [4:0]        apu_rflags_i,
    output logic              wb_valid_o,
    output logic [TAG_W-1:0]  wb_tag_o,
    output logic [31:0]       wb_data_o,
    output logic [4:0]        wb_flags_o,
    output logic [4:0]        fflags_o,
    input  logic              fflags_clr_i,
    output logic              busy_o,
    output logic              err_o
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;

    logic [1:0]       state, state_d;
    logic [2:0]       cnt, cnt_d, slot;
    logic [2:0]       rnd;
    logic [TAG_W-1:0] tag;
    logic [TAG_W-1:0] fifo   [MAX_OUTST];
    logic [TAG_W-1:0] fifo_d [MAX_OUTST];
    logic             accept, gnt, pop;

    assign apu_req_o   = state == ISSUE;
    assign op_ready_o  = rst_ni && state != ISSUE && cnt < 3'(MAX_OUTST);
    assign busy_o      = state != IDLE;
    assign apu_flags_o = {2'b10, 6'b0, rnd};
    assign accept      = op_valid_i && op_ready_o;
    assign gnt         = apu_req_o && apu_gnt_i;
    assign pop         = apu_rvalid_i && (cnt != 3'd0 || gnt);

    always_comb begin
        cnt_d   = cnt + {2'b0, gnt} - {2'b0, pop};
        slot    = cnt - {2'b0, pop};
        state_d = accept ? ISSUE : state == ISSUE ? (gnt ? WAIT : ISSUE) : cnt_d == 3'd0 ? IDLE : WAIT;
        for (int i = 0; i < MAX_OUTST; i++) fifo_d[i] = pop ? '0 : fifo[i];
        for (int i = 1; i < MAX_OUTST; i++) if (pop) fifo_d[i-1] = fifo[i];
        // a grant popped in the same cycle on an empty FIFO is forwarded, never stored
        for (int i = 0; i < MAX_OUTST; i++)
            if (gnt && !(cnt == 3'd0 && pop) && i == int'(slot)) fifo_d[i] = tag;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state          <= IDLE;
            cnt            <= '0;
            rnd            <= '0;
            tag            <= '0;
            apu_operands_o <= '0;
            apu_op_o       <= '0;
            for (int i = 0; i < MAX_OUTST; i++) fifo[i] <= '0;
            wb_valid_o     <= 1'b0;
            wb_tag_o       <= '0;
            wb_data_o      <= '0;
            wb_flags_o     <= '0;
            fflags_o       <= '0;
            err_o          <= 1'b0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            fifo       <= fifo_d;
            wb_valid_o <= pop;
            if (accept) begin
                apu_operands_o <= op_operands_i;
                apu_op_o       <= op_code_i;
                rnd            <= op_rnd_i;
                tag            <= op_tag_i;
            end
            if (pop) begin
                wb_tag_o   <= cnt == 3'd0 ? tag : fifo[0];
                wb_data_o  <= apu_rdata_i;
                wb_flags_o <= apu_rflags_i;
            end
            fflags_o <= pop ? (fflags_clr_i ? apu_rflags_i : fflags_o | apu_rflags_i) : (fflags_clr_i ? 5'd0 : fflags_o);
            if (apu_rvalid_i && !pop) err_o <= 1'b1;
        end
    end
endmodule

// File: doc/apu_dispatcher.md
APU_DISPATCHER -- requirements
Module: apu_dispatcher

Interface
REQ-001 The block SHALL have parameter MAX_OUTST, default 2: maximum granted-but-unreturned APU operations (range 1..4).
REQ-002 The block SHALL have parameter TAG_W, default 5: destination-register tag width.
REQ-003 The block SHALL have port clk_i, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-004 The block SHALL have port rst_ni, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port op_valid_i, input, 1 bit: core offers an FP operation.
REQ-006 The block SHALL have port op_ready_o, output, 1 bit: dispatcher accepts the operation this cycle.
REQ-007 The block SHALL have port op_operands_i, input, 3x32 bits: operands a, b, c.
REQ-008 The block SHALL have port op_code_i, input, 6 bits: APU operation code.
REQ-009 The block SHALL have port op_rnd_i, input, 3 bits: rounding mode.
REQ-010 The block SHALL have port op_tag_i, input, TAG_W bits: destination tag.
REQ-011 The block SHALL have port apu_req_o, output, 1 bit: request to the FP wrapper.
REQ-012 The block SHALL have port apu_gnt_i, input, 1 bit: grant from the FP wrapper.
REQ-013 The block SHALL have port apu_operands_o, output, 3x32 bits: operands to the APU.
REQ-014 The block SHALL have port apu_op_o, output, 6 bits: operation to the APU.
REQ-015 The block SHALL have port apu_flags_o, output, 11 bits: {2'b10, 3'b000, 3'b000, rnd}.
REQ-016 The block SHALL have port apu_rvalid_i, input, 1 bit: APU result valid.
REQ-017 The block SHALL have port apu_rdata_i, input, 32 bits: APU result.
REQ-018 The block SHALL have port apu_rflags_i, input, 5 bits: APU exception flags {NV,DZ,OF,UF,NX}.
REQ-019 The block SHALL have port wb_valid_o, output, 1 bit: writeback strobe, asserted for one cycle per result.
REQ-020 The block SHALL have port wb_tag_o, output, TAG_W bits: tag of the result.
REQ-021 The block SHALL have port wb_data_o, output, 32 bits: result data.
REQ-022 The block SHALL have port wb_flags_o, output, 5 bits: flags of this result.
REQ-023 The block SHALL have port fflags_o, output, 5 bits: sticky OR of all returned flags.
REQ-024 The block SHALL have port fflags_clr_i, input, 1 bit: clear the sticky flags.
REQ-025 The block SHALL have port busy_o, output, 1 bit: request pending or results outstanding.
REQ-026 The block SHALL have port err_o, output, 1 bit: sticky protocol-error flag.

Function
REQ-027 State machine SHALL be IDLE (no pending request, cnt=0), ISSUE (apu_req_o=1), WAIT (no pending request, cnt>0); cnt = granted-unreturned count, 0..MAX_OUTST.
REQ-028 op_ready_o SHALL equal (state != ISSUE) && (cnt < MAX_OUTST), computed from registered state only.
REQ-029 On op_valid_i && op_ready_o, operands, code, rnd and tag SHALL be registered, and apu_req_o SHALL assert the next cycle (state -> ISSUE).
REQ-030 In ISSUE, apu_req_o, apu_operands_o, apu_op_o and apu_flags_o SHALL hold stable until the cycle in which apu_gnt_i=1.
REQ-031 On a grant, the tag SHALL be pushed into a MAX_OUTST-deep in-order tag FIFO, cnt SHALL increment, and the next state SHALL be WAIT.
REQ-032 apu_gnt_i while apu_req_o=0 SHALL be ignored.
REQ-033 On apu_rvalid_i with cnt>0, the FIFO head SHALL be popped and cnt SHALL decrement; one cycle later, wb_valid_o=1 with wb_tag_o=head, wb_data_o=apu_rdata_i and wb_flags_o=apu_rflags_i, all registered.
REQ-034 A grant and an rvalid in the same cycle (zero-latency FPU) SHALL push and pop together; cnt SHALL remain unchanged, and an empty FIFO SHALL forward the pushed tag.
REQ-035 apu_rvalid_i with cnt=0 and no same-cycle grant SHALL set err_o, SHALL produce no writeback, and SHALL leave the FIFO unchanged.
REQ-036 fflags_o SHALL OR in apu_rflags_i on every accepted rvalid; fflags_clr_i SHALL clear it, and a same-cycle rvalid SHALL win (new flags loaded into the cleared value).
REQ-037 WAIT SHALL go to IDLE when cnt reaches 0 and no operation is accepted.
REQ-038 busy_o SHALL equal (state != IDLE).
REQ-039 Results SHALL be returned in grant order; no wb backpressure exists.

Reset
REQ-040 While rst_ni=0: state=IDLE, cnt=0, FIFO empty, and apu_req_o, op_ready_o (forced 0), wb_valid_o, busy_o, err_o and fflags_o SHALL all be 0; data outputs SHALL be 0.
REQ-041 Reset asserted mid-operation SHALL discard the pending request and all outstanding tags; rvalid after reset release SHALL flag err_o.
REQ-042 op_ready_o SHALL be 1 in the first cycle after release.

Verification
REQ-043 Scenario: op_code 6'b001100, rnd 3'b011, a=32'h10, tag 3; gnt and rvalid in the same cycle with rdata 32'h41800000 -> apu_flags_o=11'h403; one cycle later, wb_valid_o=1, tag 3, data 32'h41800000.
REQ-044 Scenario: gnt withheld for 4 cycles -> apu_req_o and the operands are stable for all 4 cycles; op_ready_o=0 throughout.
REQ-045 Scenario: issue tags 1 and 2 with MAX_OUTST=2 and no rvalid -> op_ready_o=0 after the second grant; two rvalids -> wb tags 1 then 2, with op_ready_o=1 after the first return.
REQ-046 Scenario: returns with rflags 5'b00001 then 5'b10000 -> fflags_o=5'b10001; fflags_clr_i with a same-cycle rvalid carrying 5'b00100 -> fflags_o=5'b00100.
REQ-047 Scenario: rvalid with cnt=0 -> err_o=1, wb_valid_o stays 0.
REQ-048 Scenario: rst_ni low during ISSUE -> apu_req_o=0 immediately (asynchronously), busy_o=0, cnt=0.
